// File: rtl/seq_add_sub.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : seq_add_sub                                              |
// | Description : Chunk-serial two's-complement adder/subtractor. Takes an |
// |               n-bit operand pair, processes w bits per cycle and holds |
// |               the result until the consumer accepts it.                |
// |               Optional macro SEQ_ADD_SUB_SAT_EN: saturate s on signed  |
// |               overflow instead of wrapping.                            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module seq_add_sub #(
  parameter int n = 16,
  parameter int w = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         control_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] s,
  output logic         cout,
  output logic         overflow,
  output logic         zero
);

  localparam int c_chunks = n / w;
  localparam int c_k_w    = (c_chunks > 1) ? $clog2(c_chunks) : 1;
  localparam logic [c_k_w-1:0] c_last = c_k_w'(c_chunks - 1);

  // Reject geometries where the operand cannot be split into whole chunks.
  generate
    if (n < 2 || w < 1 || w > n || (n % w) != 0) begin : g_param_check
      $error("seq_add_sub: need n >= 2, 1 <= w <= n and n %% w == 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [n-1:0]      r_x;
  logic [n-1:0]      r_y;        // y already inverted for subtract
  logic              r_carry;
  logic [c_k_w-1:0]  r_k;
  logic [n-1:0]      r_acc;      // partial unsaturated result
  logic [n-1:0]      r_s;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;

  int                w_idx;
  logic [w-1:0]      w_x_chunk;
  logic [w-1:0]      w_y_chunk;
  logic [w:0]        w_sum;
  logic [n-1:0]      w_acc_next;
  logic              w_ovf;
  logic [n-1:0]      w_s_final;
  logic              w_last;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: accept in IDLE, step through chunks, wait for consumer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  // One chunk of ripple addition plus the final overflow/saturation view.
  always_comb begin
    w_last     = (r_k == c_last);
    w_idx      = int'(r_k) * w;
    w_x_chunk  = r_x[w_idx +: w];
    w_y_chunk  = r_y[w_idx +: w];
    w_sum      = {1'b0, w_x_chunk} + {1'b0, w_y_chunk} + {{w{1'b0}}, r_carry};
    w_acc_next = r_acc;
    w_acc_next[w_idx +: w] = w_sum[w-1:0];
    // Only meaningful on the last chunk, which holds the sign bit.
    w_ovf = (~r_x[n-1] & ~r_y[n-1] &  w_acc_next[n-1]) |
            ( r_x[n-1] &  r_y[n-1] & ~w_acc_next[n-1]);
`ifdef SEQ_ADD_SUB_SAT_EN
    if (w_ovf) w_s_final = r_x[n-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
    else       w_s_final = w_acc_next;
`else
    w_s_final = w_acc_next;
`endif
  end

  // Operand capture, chunk accumulation and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= x;
            r_y     <= y ^ {n{control_bit}};
            r_carry <= control_bit;
            r_k     <= '0;
            r_acc   <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_sum[w];
          r_k     <= r_k + c_k_w'(1);
          if (w_last) begin
            r_s    <= w_s_final;
            r_cout <= w_sum[w];
            r_ovf  <= w_ovf;
            r_zero <= (w_s_final == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_add_sub.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_seq_add_sub                                           |
// | Description : Self-checking bench for seq_add_sub (n=16/w=4 and        |
// |               n=8/w=8 instances) with an expected-result queue.        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_seq_add_sub;

  localparam int N   = 16;
  localparam int W   = 4;
  localparam int LAT = N / W;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, control_bit, out_valid, out_ready;
  logic [N-1:0] x, y, s;
  logic        cout, overflow, zero;

  logic        in_valid8, in_ready8, control_bit8, out_valid8, out_ready8;
  logic [7:0]  x8, y8, s8;
  logic        cout8, overflow8, zero8;

  always #5 clk = ~clk;

  seq_add_sub #(.n(N), .w(W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .control_bit(control_bit), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .overflow(overflow), .zero(zero)
  );

  seq_add_sub #(.n(8), .w(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .y(y8), .control_bit(control_bit8), .out_valid(out_valid8),
    .out_ready(out_ready8), .s(s8), .cout(cout8), .overflow(overflow8), .zero(zero8)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  res_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Whole-word arithmetic reference.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic cb);
    logic [15:0] bi;
    logic [16:0] t;
    res_t        r;
    bi     = b ^ {16{cb}};
    t      = {1'b0, a} + {1'b0, bi} + {16'd0, cb};
    r.cout = t[16];
    r.ovf  = (~a[15] & ~bi[15] & t[15]) | (a[15] & bi[15] & ~t[15]);
    r.s    = t[15:0];
`ifdef SEQ_ADD_SUB_SAT_EN
    if (r.ovf) r.s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    r.zero = (r.s == 16'h0000);
    return r;
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cb);
    @(negedge clk);
    x = a; y = b; control_bit = cb; in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    sb_q.push_back(model(a, b, cb));
    #1;
    in_valid = 1'b0;
    x = 16'($urandom); y = 16'($urandom); control_bit = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume(input int hold);
    res_t e;
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 0, 1);
      e = '0;
    end else begin
      e = sb_q.pop_front();
    end
    check("s", s, e.s);
    check("cout", cout, e.cout);
    check("overflow", overflow, e.ovf);
    check("zero", zero, e.zero);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid = 1'b1; x = 16'($urandom); y = 16'($urandom);
      control_bit = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_result", {s, cout, overflow, zero}, e);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_drop", out_valid, 0);
    check("in_ready_return", in_ready, 1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cb, input int hold);
    int lat;
    issue(a, b, cb);
    wait_result(lat);
    check("latency", lat, LAT);
    consume(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; control_bit = 1'b0; x = '0; y = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; control_bit8 = 1'b0; x8 = '0; y8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {s, cout, overflow, zero}, 0);
    rst = 1'b0;
    #1 check("in_ready_after_rst", in_ready, 1);

    run_op(16'h0005, 16'h0003, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h1234, 16'h1234, 1'b1, 0);
    run_op(16'h0005, 16'h0007, 1'b1, 3);
    run_op(16'h8000, 16'h0001, 1'b1, 1);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), i % 2);

    // Reset during the second RUN cycle discards the operation.
    issue(16'h0001, 16'h0002, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("in_ready_in_rst", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_outputs", {s, cout, overflow, zero}, 0);
    check("post_rst_in_ready", in_ready, 1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("no_pulse_after_rst", pulses, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 0);

    // n=8, w=8: single-cycle RUN.
    @(negedge clk);
    x8 = 8'h80; y8 = 8'h01; control_bit8 = 1'b1; in_valid8 = 1'b1;
    check("in_ready8", in_ready8, 1);
    @(posedge clk);
    #1 in_valid8 = 1'b0; x8 = 8'h00; y8 = 8'h00;
    @(negedge clk);
    check("w8_run_not_valid", out_valid8, 0);
    @(negedge clk);
    check("w8_latency1_valid", out_valid8, 1);
`ifdef SEQ_ADD_SUB_SAT_EN
    check("w8_s", s8, 8'h80);
`else
    check("w8_s", s8, 8'h7F);
`endif
    check("w8_overflow", overflow8, 1);
    check("w8_cout", cout8, 1);
    check("w8_zero", zero8, 0);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1 out_ready8 = 1'b0;
    @(negedge clk);
    check("w8_in_ready_return", in_ready8, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_add_sub.md
SEQ_ADD_SUB -- requirements
Module: seq_add_sub

Interface
REQ-001 Parameter n, default 16, total operand width in bits; n >= 2.
REQ-002 Parameter w, default 4, chunk width processed per cycle; 1 <= w <= n; n % w == 0, otherwise elaboration SHALL fail.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operands and control_bit are valid this cycle.
REQ-006 in_ready  output  1  block can accept a new operation.
REQ-007 x, y  input  n each  operands, two's complement.
REQ-008 control_bit  input  1  0 = add (x+y), 1 = subtract (x-y).
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 s  output  n  sum or difference.
REQ-012 cout  output  1  carry out of bit n-1; for subtract, 1 means no borrow.
REQ-013 overflow  output  1  signed overflow of the result.
REQ-014 zero  output  1  s == 0, evaluated after any saturation.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE with rst low; otherwise it is 0.
REQ-017 On in_valid & in_ready, the block SHALL:
- latch x, y_in = y XOR {n{control_bit}}, and carry = control_bit;
- clear the chunk counter;
- go to RUN.
REQ-018 Each RUN cycle, for chunk k, the block SHALL:
- compute {c, s[k*w +: w]} = x[k*w +: w] + y_in[k*w +: w] + carry;
- store c as the new carry;
- increment k.
REQ-019 After chunk n/w-1, the block SHALL go to DONE and assert out_valid, exactly n/w cycles after the accept edge.
REQ-020 overflow SHALL be (~x[n-1] & ~y_in[n-1] & s_raw[n-1]) | (x[n-1] & y_in[n-1] & ~s_raw[n-1]), where s_raw is the unsaturated result; cout = final carry.
REQ-021 In DONE, s, cout, overflow, zero and out_valid SHALL hold stable until out_ready is 1.
REQ-022 On out_valid & out_ready, the block SHALL return to IDLE and deassert out_valid on the next cycle; there is no overlap, so in_ready is 1 on that following cycle.
REQ-023 In IDLE and RUN, out_valid SHALL be 0 and s, cout, overflow, zero are don't-care.
REQ-024 in_valid SHALL be ignored outside IDLE, and x, y and control_bit changes after accept SHALL NOT affect the result.
REQ-025 With w == n, RUN SHALL last one cycle (latency 1).

Reset
REQ-026 When rst is 1, the block SHALL enter IDLE and set s=0, cout=0, overflow=0, zero=0, out_valid=0, in_ready=0, carry=0 and k=0, regardless of state, including mid-RUN and in DONE.
REQ-027 An operation in flight at reset SHALL be discarded with no out_valid pulse, and in_ready SHALL be 1 on the first cycle after rst falls.

Configuration
REQ-028 Macro SEQ_ADD_SUB_SAT_EN SHALL select saturating output.
- Defined: when overflow=1, s is clamped to 0111…1 if x[n-1]=0, or to 1000…0 if x[n-1]=1; overflow still reads 1 and cout is unchanged.
- Undefined: s is the wrapped result s_raw.

Verification (n=16, w=4 unless noted)
REQ-029 Add 0x0005 + 0x0003 -> s=0x0008, cout=0, overflow=0, zero=0; out_valid exactly 4 cycles after the accept edge.
REQ-030 Add 0x7FFF + 0x0001 -> overflow=1, cout=0; s=0x8000 without SEQ_ADD_SUB_SAT_EN, s=0x7FFF with it.
REQ-031 Subtract 0x1234 - 0x1234 -> s=0x0000, cout=1, zero=1; subtract 0x0005 - 0x0007 -> s=0xFFFE, cout=0, overflow=0.
REQ-032 Hold out_ready=0 for 3 cycles in DONE while toggling x, y and in_valid -> outputs stay stable, in_ready=0; on release, in_ready=1 the next cycle.
REQ-033 Assert rst for 1 cycle during the 2nd RUN cycle -> no out_valid pulse, all outputs 0, in_ready=1 after reset; a new add 0x0001 + 0x0001 then gives s=0x0002.
REQ-034 With n=8, w=8, subtract 0x80 - 0x01 -> s=0x7F, overflow=1, latency 1; with saturation, s=0x80.
